mm_rd_sched: RTL and testbench
==============================

# mm_rd_sched

Read-side scheduler for the banked A/B operand memories of the matrix-multiply engine. When the loader raises `start_multiply`, the block walks every output tile (row-block i, column-block j) and streams the shared k-dimension addresses into `rd_addr_A`/`rd_addr_B` with a read enable. It then drains the systolic pipeline and returns `done_multiply`, which closes the loader's start/done handshake. It sits in the fast-clock domain between the stream-to-memory loader and the PE array.

## Interface
Parameters:
- `MATRIXSIZE_W`, 16, width of the size inputs and the internal loop counters.
- `ADDR_W_A`, 12, A read-address width.
- `ADDR_W_B`, 12, B read-address width.
- `DRAIN_CYC`, 8, number of cycles after the last read before `done_multiply` is raised (≥1).

Ports:
- `clk` in 1: sole clock (fast compute clock).
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_multiply` in 1: level request; held high until `done_multiply` is seen.
- `M2` in MATRIXSIZE_W: shared k-dimension length.
- `M1dN1` in MATRIXSIZE_W: number of A row-blocks.
- `M3dN2` in MATRIXSIZE_W: number of B column-blocks.
- `stall` in 1: PE array back-pressure; freezes issue.
- `rd_addr_A` out ADDR_W_A: A bank read address.
- `rd_addr_B` out ADDR_W_B: B bank read address.
- `rd_en` out 1: addresses valid this cycle.
- `tile_first` out 1: with `rd_en`, marks k==0 of a tile.
- `tile_last` out 1: with `rd_en`, marks k==M2-1 of a tile.
- `busy` out 1: high in every state except IDLE.
- `done_multiply` out 1: job complete.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE → LOAD when `start_multiply`=1. LOAD latches M2, M1dN1 and M3dN2, and clears the counters k, j, i and the bases `a_base` and `b_base`. Size inputs are ignored outside LOAD.
- LOAD → DONE if any latched size is 0 (no reads issued). Otherwise LOAD → RUN.
- RUN, `stall`=0:
  - `rd_en`=1, `rd_addr_A`=a_base+k, `rd_addr_B`=b_base+k.
  - k increments. On k==M2-1: k←0, j increments, b_base += M2.
  - On j==M3dN2-1 as well: j←0, b_base←0, i increments, a_base += M2.
  - Loop order: i outer, j middle, k inner.
- RUN, `stall`=1: `rd_en`=0 and all counters and bases hold. Stall affects only RUN.
- The last issue (i==M1dN1-1, j==M3dN2-1, k==M2-1) moves to DRAIN. The drain counter loads DRAIN_CYC-1.
- DRAIN counts down to 0 → DONE.
- DONE holds `done_multiply`=1 until `start_multiply`=0, then → IDLE.
- Address arithmetic: bases and sums are computed at full MATRIXSIZE_W width, then truncated to ADDR_W_x, so addresses wrap modulo 2^ADDR_W. Range checking is the loader's responsibility.
- If `start_multiply` drops mid-job, the job still completes. DONE then exits on the next cycle.

## Timing
- Reset values of all outputs are 0. State resets to IDLE, and all counters and bases reset to 0.
- All outputs are registered.
- `start_multiply` sampled high at edge t:
  - LOAD at t+1.
  - First `rd_en` visible after edge t+2.
- Issue rate: one address pair per unstalled cycle. A job takes M1dN1·M3dN2·M2 issue cycles plus stall cycles.
- `stall` sampled at edge e suppresses the issue registered at e. No skid is needed.
- `done_multiply` rises exactly DRAIN_CYC+1 cycles after the cycle of the last `rd_en`. It falls one cycle after `start_multiply` is sampled low.
- A new job cannot start before IDLE is re-entered. Minimum gap between `done_multiply` falling and the next first `rd_en` is 3 cycles.

## Configuration
- `MM_RD_SCHED_PERF_EN` defined:
  - Adds output `stall_cnt` [31:0], which counts RUN cycles with `stall`=1.
  - Adds output `job_cnt` [MATRIXSIZE_W-1:0], which increments on each DONE → IDLE transition.
  - Both counters saturate at all-ones, and both reset to 0 on `rst_n`.
  - `stall_cnt` clears in LOAD.
- Macro absent: neither port exists and no counter logic is built.

## Test plan
- M2=3, M1dN1=1, M3dN2=2, no stall → 6 `rd_en` pulses. A addresses 0,1,2,0,1,2. B addresses 0,1,2,3,4,5. `tile_first` on pulses 1 and 4, `tile_last` on pulses 3 and 6. `done_multiply` rises 9 cycles after the last `rd_en` (DRAIN_CYC=8).
- M2=2, M1dN1=2, M3dN2=2 → A sequence 0,1,0,1,2,3,2,3 and B sequence 0,1,2,3,0,1,2,3.
- Same as the first case with `stall` held high for 4 cycles mid-tile → identical address sequence with no duplicates or skips, completing 4 cycles later. `stall_cnt`=4 when PERF is enabled.
- M3dN2=0 → no `rd_en`. `done_multiply` is high 2 cycles after start is sampled. It clears 1 cycle after `start_multiply` drops, and `busy` falls with it.
- `rst_n` asserted low mid-RUN → all outputs are 0 immediately, without waiting for a clock edge. After release with `start_multiply` high, the job restarts from address 0.
- ADDR_W_A=4, M2=5, M1dN1=4 → the A base wraps past 15 (the base 15 row issues 15,0,1,2,3). No X values appear and the FSM does not hang.

Source files
------------

// File: rtl/mm_rd_sched.sv
// Read-address scheduler for the banked A/B operand memories: walks every output tile and streams k addresses.
// Optional performance counters (stall_cnt, job_cnt) are built when MM_RD_SCHED_PERF_EN is defined.
module mm_rd_sched #(
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W_A     = 12,
  parameter int ADDR_W_B     = 12,
  parameter int DRAIN_CYC    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_multiply,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] M3dN2,
  input  logic                    stall,
  output logic [ADDR_W_A-1:0]     rd_addr_A,
  output logic [ADDR_W_B-1:0]     rd_addr_B,
  output logic                    rd_en,
  output logic                    tile_first,
  output logic                    tile_last,
  output logic                    busy,
  output logic                    done_multiply
`ifdef MM_RD_SCHED_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [MATRIXSIZE_W-1:0] job_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t state, state_nxt;

  logic [MATRIXSIZE_W-1:0] m2_q, m1_q, m3_q;
  logic [MATRIXSIZE_W-1:0] m2_nxt, m1_nxt, m3_nxt;
  logic [MATRIXSIZE_W-1:0] k, j, i;
  logic [MATRIXSIZE_W-1:0] k_nxt, j_nxt, i_nxt;
  logic [MATRIXSIZE_W-1:0] a_base, b_base;
  logic [MATRIXSIZE_W-1:0] a_base_nxt, b_base_nxt;
  logic [DRAIN_W-1:0]      drain_cnt, drain_nxt;

  logic [ADDR_W_A-1:0] addr_a_nxt;
  logic [ADDR_W_B-1:0] addr_b_nxt;
  logic                rd_en_nxt, first_nxt, last_nxt, busy_nxt, done_nxt;

  logic last_k, last_j, last_i;

  assign last_k = (k == m2_q - MATRIXSIZE_W'(1));
  assign last_j = (j == m3_q - MATRIXSIZE_W'(1));
  assign last_i = (i == m1_q - MATRIXSIZE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // busy/done follow the state register, so they lag the FSM by one cycle
  always_comb begin
    state_nxt  = state;
    m2_nxt     = m2_q;
    m1_nxt     = m1_q;
    m3_nxt     = m3_q;
    k_nxt      = k;
    j_nxt      = j;
    i_nxt      = i;
    a_base_nxt = a_base;
    b_base_nxt = b_base;
    drain_nxt  = drain_cnt;
    addr_a_nxt = rd_addr_A;
    addr_b_nxt = rd_addr_B;
    rd_en_nxt  = 1'b0;
    first_nxt  = 1'b0;
    last_nxt   = 1'b0;
    busy_nxt   = (state != IDLE);
    done_nxt   = (state == DONE);

    case (state)
      IDLE: begin
        if (start_multiply) state_nxt = LOAD;
      end
      LOAD: begin
        m2_nxt     = M2;
        m1_nxt     = M1dN1;
        m3_nxt     = M3dN2;
        k_nxt      = '0;
        j_nxt      = '0;
        i_nxt      = '0;
        a_base_nxt = '0;
        b_base_nxt = '0;
        if (M2 == '0 || M1dN1 == '0 || M3dN2 == '0) state_nxt = DONE;
        else                                        state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          rd_en_nxt  = 1'b1;
          addr_a_nxt = ADDR_W_A'(a_base + k);
          addr_b_nxt = ADDR_W_B'(b_base + k);
          first_nxt  = (k == '0);
          last_nxt   = last_k;
          if (last_k) begin
            k_nxt = '0;
            if (last_j) begin
              j_nxt      = '0;
              b_base_nxt = '0;
              i_nxt      = i + MATRIXSIZE_W'(1);
              a_base_nxt = a_base + m2_q;
              if (last_i) begin
                state_nxt = DRAIN;
                drain_nxt = DRAIN_W'(DRAIN_CYC - 1);
              end
            end else begin
              j_nxt      = j + MATRIXSIZE_W'(1);
              b_base_nxt = b_base + m2_q;
            end
          end else begin
            k_nxt = k + MATRIXSIZE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = DONE;
        else                 drain_nxt = drain_cnt - DRAIN_W'(1);
      end
      DONE: begin
        if (!start_multiply) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_q          <= '0;
      m1_q          <= '0;
      m3_q          <= '0;
      k             <= '0;
      j             <= '0;
      i             <= '0;
      a_base        <= '0;
      b_base        <= '0;
      drain_cnt     <= '0;
      rd_addr_A     <= '0;
      rd_addr_B     <= '0;
      rd_en         <= 1'b0;
      tile_first    <= 1'b0;
      tile_last     <= 1'b0;
      busy          <= 1'b0;
      done_multiply <= 1'b0;
    end else begin
      m2_q          <= m2_nxt;
      m1_q          <= m1_nxt;
      m3_q          <= m3_nxt;
      k             <= k_nxt;
      j             <= j_nxt;
      i             <= i_nxt;
      a_base        <= a_base_nxt;
      b_base        <= b_base_nxt;
      drain_cnt     <= drain_nxt;
      rd_addr_A     <= addr_a_nxt;
      rd_addr_B     <= addr_b_nxt;
      rd_en         <= rd_en_nxt;
      tile_first    <= first_nxt;
      tile_last     <= last_nxt;
      busy          <= busy_nxt;
      done_multiply <= done_nxt;
    end
  end

`ifdef MM_RD_SCHED_PERF_EN
  // Saturating counters; stall_cnt restarts with every job, job_cnt only on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      job_cnt   <= '0;
    end else begin
      if (state == LOAD) begin
        stall_cnt <= '0;
      end else if (state == RUN && stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (state == DONE && !start_multiply && job_cnt != '1) begin
        job_cnt <= job_cnt + MATRIXSIZE_W'(1);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_mm_rd_sched.sv
// Directed self-checking bench for mm_rd_sched: address sequences, stall, drain timing, reset and wrap.
module tb_mm_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_multiply = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] M2 = '0, M1dN1 = '0, M3dN2 = '0;
  logic [11:0] rd_addr_A, rd_addr_B;
  logic        rd_en, tile_first, tile_last, busy, done_multiply;

  logic        w_start = 1'b0;
  logic        w_stall = 1'b0;
  logic [15:0] w_M2 = '0, w_M1 = '0, w_M3 = '0;
  logic [3:0]  w_addr_A;
  logic [11:0] w_addr_B;
  logic        w_rd_en, w_first, w_last, w_busy, w_done;

`ifdef MM_RD_SCHED_PERF_EN
  logic [31:0] stall_cnt, w_stall_cnt;
  logic [15:0] job_cnt, w_job_cnt;
`endif

  mm_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .start_multiply(start_multiply),
    .M2(M2), .M1dN1(M1dN1), .M3dN2(M3dN2), .stall(stall),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B), .rd_en(rd_en),
    .tile_first(tile_first), .tile_last(tile_last),
    .busy(busy), .done_multiply(done_multiply)
`ifdef MM_RD_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .job_cnt(job_cnt)
`endif
  );

  mm_rd_sched #(.ADDR_W_A(4), .DRAIN_CYC(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .start_multiply(w_start),
    .M2(w_M2), .M1dN1(w_M1), .M3dN2(w_M3), .stall(w_stall),
    .rd_addr_A(w_addr_A), .rd_addr_B(w_addr_B), .rd_en(w_rd_en),
    .tile_first(w_first), .tile_last(w_last),
    .busy(w_busy), .done_multiply(w_done)
`ifdef MM_RD_SCHED_PERF_EN
    , .stall_cnt(w_stall_cnt), .job_cnt(w_job_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] qA[$], qB[$], wA[$], wB[$];
  logic        qF[$], qL[$];
  int          qC[$];

  // Capture every issued address pair just after the edge that registered it
  always @(posedge clk) begin
    #1;
    if (rd_en !== 1'b0) begin
      qA.push_back({20'b0, rd_addr_A});
      qB.push_back({20'b0, rd_addr_B});
      qF.push_back(tile_first);
      qL.push_back(tile_last);
      qC.push_back(cyc);
    end
    if (w_rd_en !== 1'b0) begin
      wA.push_back({28'b0, w_addr_A});
      wB.push_back({20'b0, w_addr_B});
    end
  end

  int checks = 0;
  int failures = 0;
  int start_cyc, done_cyc;

  task automatic clear_queues();
    qA.delete(); qB.delete(); qF.delete(); qL.delete(); qC.delete();
  endtask

  task automatic run_job(input int m2, input int m1, input int m3,
                         input int stall_after, input int stall_len, output bit finished);
    int stalled;
    clear_queues();
    finished = 1'b0;
    stalled  = 0;
    done_cyc = -1;
    @(negedge clk);
    M2 = 16'(m2); M1dN1 = 16'(m1); M3dN2 = 16'(m3);
    start_multiply = 1'b1;
    start_cyc = cyc + 1;
    for (int b = 0; b < 1000; b++) begin
      @(negedge clk);
      if (cyc == start_cyc + 1) begin
        M2 = 16'd7; M1dN1 = 16'd7; M3dN2 = 16'd7;
      end
      if (done_multiply === 1'b1) begin
        done_cyc = cyc;
        finished = 1'b1;
        break;
      end
      if (stall_len > 0 && qA.size() == stall_after && stalled < stall_len) begin
        stall = 1'b1;
        stalled++;
      end else begin
        stall = 1'b0;
      end
    end
    stall = 1'b0;
  endtask

  task automatic end_job();
    @(negedge clk) start_multiply = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #17;
    checks++;
    if ({rd_en, tile_first, tile_last, busy, done_multiply} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {rd_en, tile_first, tile_last, busy, done_multiply});
    end
    checks++;
    if ({rd_addr_A, rd_addr_B} !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_addr: got %h expected 000000", {rd_addr_A, rd_addr_B});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_row();
    int expA[6] = '{0, 1, 2, 0, 1, 2};
    int expB[6] = '{0, 1, 2, 3, 4, 5};
    bit expF[6] = '{1, 0, 0, 1, 0, 0};
    bit expL[6] = '{0, 0, 1, 0, 0, 1};
    bit fin;
    run_job(3, 1, 2, 0, 0, fin);
    checks++;
    if (!fin || qA.size() != 6) begin
      failures++;
      $display("[TB] FAIL single_row_count: got %0d pulses done=%0d expected 6 done=1", qA.size(), fin);
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (n >= qA.size() || qA[n] !== expA[n] || qB[n] !== expB[n] ||
          qF[n] !== expF[n] || qL[n] !== expL[n]) begin
        failures++;
        $display("[TB] FAIL single_row_pulse%0d: got A=%0d B=%0d f=%b l=%b expected A=%0d B=%0d f=%b l=%b",
                 n, (n < qA.size()) ? qA[n] : -1, (n < qB.size()) ? qB[n] : -1,
                 (n < qF.size()) ? qF[n] : 1'bx, (n < qL.size()) ? qL[n] : 1'bx,
                 expA[n], expB[n], expF[n], expL[n]);
      end
    end
    checks++;
    if (qC.size() != 6 || done_cyc - qC[5] != 9) begin
      failures++;
      $display("[TB] FAIL single_row_drain: got %0d cycles expected 9",
               (qC.size() == 6) ? done_cyc - qC[5] : -1);
    end
    checks++;
    if (qC.size() == 0 || qC[0] - start_cyc != 2) begin
      failures++;
      $display("[TB] FAIL single_row_latency: got %0d expected 2",
               (qC.size() > 0) ? qC[0] - start_cyc : -1);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_row_busy: got %b expected 1", busy);
    end
    end_job();
    checks++;
    if (done_multiply !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_row_idle: got done=%b busy=%b expected 0 0", done_multiply, busy);
    end
  endtask

  task automatic test_multi_row();
    int expA[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int expB[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit fin;
    run_job(2, 2, 2, 0, 0, fin);
    checks++;
    if (!fin || qA.size() != 8) begin
      failures++;
      $display("[TB] FAIL multi_row_count: got %0d pulses expected 8", qA.size());
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (n >= qA.size() || qA[n] !== expA[n] || qB[n] !== expB[n]) begin
        failures++;
        $display("[TB] FAIL multi_row_pulse%0d: got A=%0d B=%0d expected A=%0d B=%0d",
                 n, (n < qA.size()) ? qA[n] : -1, (n < qB.size()) ? qB[n] : -1, expA[n], expB[n]);
      end
    end
    checks++;
    if (done_cyc - start_cyc != 18) begin
      failures++;
      $display("[TB] FAIL multi_row_time: got %0d expected 18", done_cyc - start_cyc);
    end
    end_job();
  endtask

  task automatic test_stall();
    int expA[6] = '{0, 1, 2, 0, 1, 2};
    int expB[6] = '{0, 1, 2, 3, 4, 5};
    bit fin;
    run_job(3, 1, 2, 2, 4, fin);
    checks++;
    if (!fin || qA.size() != 6) begin
      failures++;
      $display("[TB] FAIL stall_count: got %0d pulses expected 6", qA.size());
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (n >= qA.size() || qA[n] !== expA[n] || qB[n] !== expB[n]) begin
        failures++;
        $display("[TB] FAIL stall_pulse%0d: got A=%0d B=%0d expected A=%0d B=%0d",
                 n, (n < qA.size()) ? qA[n] : -1, (n < qB.size()) ? qB[n] : -1, expA[n], expB[n]);
      end
    end
    checks++;
    if (qC.size() < 3 || qC[2] - qC[1] != 5) begin
      failures++;
      $display("[TB] FAIL stall_gap: got %0d expected 5", (qC.size() >= 3) ? qC[2] - qC[1] : -1);
    end
    checks++;
    if (done_cyc - start_cyc != 20) begin
      failures++;
      $display("[TB] FAIL stall_time: got %0d expected 20", done_cyc - start_cyc);
    end
`ifdef MM_RD_SCHED_PERF_EN
    checks++;
    if (stall_cnt !== 32'd4) begin
      failures++;
      $display("[TB] FAIL stall_cnt: got %0d expected 4", stall_cnt);
    end
`endif
    end_job();
`ifdef MM_RD_SCHED_PERF_EN
    checks++;
    if (job_cnt !== 16'd3) begin
      failures++;
      $display("[TB] FAIL job_cnt: got %0d expected 3", job_cnt);
    end
`endif
  endtask

  task automatic test_zero_size();
    bit fin;
    run_job(3, 1, 0, 0, 0, fin);
    checks++;
    if (!fin || done_cyc - start_cyc != 2) begin
      failures++;
      $display("[TB] FAIL zero_done_time: got %0d expected 2", done_cyc - start_cyc);
    end
    checks++;
    if (qA.size() != 0) begin
      failures++;
      $display("[TB] FAIL zero_no_reads: got %0d pulses expected 0", qA.size());
    end
    start_multiply = 1'b0;
    @(negedge clk);
    checks++;
    if (done_multiply !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_hold: got done=%b busy=%b expected 1 1", done_multiply, busy);
    end
    @(negedge clk);
    checks++;
    if (done_multiply !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_release: got done=%b busy=%b expected 0 0", done_multiply, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit fin;
    run_job(1, 3, 1, 0, 0, fin);
    checks++;
    if (!fin || qA.size() != 3) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d pulses expected 3", qA.size());
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (n >= qA.size() || qA[n] !== n || qB[n] !== 0 || qF[n] !== 1'b1 || qL[n] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_pulse%0d: got A=%0d B=%0d expected A=%0d B=0 first=1 last=1",
                 n, (n < qA.size()) ? qA[n] : -1, (n < qB.size()) ? qB[n] : -1, n);
      end
    end
    checks++;
    if (done_cyc - start_cyc != 13) begin
      failures++;
      $display("[TB] FAIL b2b_time: got %0d expected 13", done_cyc - start_cyc);
    end
    end_job();
  endtask

  task automatic test_reset_mid_run();
    int expB[6] = '{0, 1, 2, 3, 4, 5};
    clear_queues();
    @(negedge clk);
    M2 = 16'd3; M1dN1 = 16'd1; M3dN2 = 16'd2;
    start_multiply = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrun_active: got rd_en=%b expected 1", rd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, tile_first, tile_last, busy, done_multiply, rd_addr_A, rd_addr_B} !== 29'b0) begin
      failures++;
      $display("[TB] FAIL midrun_async_reset: got rd_en=%b busy=%b A=%0d B=%0d expected all 0",
               rd_en, busy, rd_addr_A, rd_addr_B);
    end
    @(negedge clk) rst_n = 1'b1;
    clear_queues();
    done_cyc = -1;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (done_multiply === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (done_cyc < 0 || qA.size() != 6) begin
      failures++;
      $display("[TB] FAIL midrun_restart_count: got %0d pulses expected 6", qA.size());
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (n >= qA.size() || qA[n] !== (n % 3) || qB[n] !== expB[n]) begin
        failures++;
        $display("[TB] FAIL midrun_restart_pulse%0d: got A=%0d B=%0d expected A=%0d B=%0d",
                 n, (n < qA.size()) ? qA[n] : -1, (n < qB.size()) ? qB[n] : -1, n % 3, expB[n]);
      end
    end
    end_job();
  endtask

  task automatic test_addr_wrap();
    bit fin = 1'b0;
    wA.delete(); wB.delete();
    @(negedge clk);
    w_M2 = 16'd5; w_M1 = 16'd4; w_M3 = 16'd1;
    w_start = 1'b1;
    for (int b = 0; b < 500; b++) begin
      @(negedge clk);
      if (w_done === 1'b1) begin
        fin = 1'b1;
        break;
      end
    end
    checks++;
    if (!fin || wA.size() != 20) begin
      failures++;
      $display("[TB] FAIL wrap_count: got %0d pulses done=%0d expected 20 done=1", wA.size(), fin);
    end
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (n >= wA.size() || wA[n] !== ((n / 5) * 5 + (n % 5)) % 16 || wB[n] !== (n % 5)) begin
        failures++;
        $display("[TB] FAIL wrap_pulse%0d: got A=%0d B=%0d expected A=%0d B=%0d",
                 n, (n < wA.size()) ? wA[n] : -1, (n < wB.size()) ? wB[n] : -1,
                 ((n / 5) * 5 + (n % 5)) % 16, n % 5);
      end
    end
    @(negedge clk) w_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (w_busy !== 1'b0 || w_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_idle: got busy=%b done=%b expected 0 0", w_busy, w_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_multi_row();
    test_stall();
    test_zero_size();
    test_back_to_back();
    test_reset_mid_run();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
